systolic_skew_feeder: RTL and testbench

Parametrised input-skew stage for the west edge of the systolic PE grid. It takes one vector of ROW lanes per beat and delays lane r by r+1 advancing cycles, which produces the diagonal wavefront the grid needs. It carries a per-lane valid bit alongside the data and applies ready/valid backpressure. A tile-level FSM drains the skew triangle after the last beat and pulses done when the bottom row has received the final element.

---
 rtl/systolic_skew_feeder.sv | 135 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// ============================================================================
// Module  : systolic_skew_feeder
// Brief   : West-edge input skew for the systolic PE grid. Lane r is delayed
//           by r+1 advancing cycles, with per-lane valid, ready/valid
//           backpressure and a drain FSM that pulses done on the last element.
//           Optional beat counter: define SKEW_FEEDER_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_skew_feeder #(
    parameter int ROW    = 9,
    parameter int DATA_W = 8
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic [ROW*DATA_W-1:0] in_west,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic [ROW*DATA_W-1:0] out_west,
    output logic [ROW-1:0]        out_lane_valid,
    output logic                  out_done,
    output logic                  out_busy
`ifdef SKEW_FEEDER_STATS_EN
    ,
    output logic [15:0]           out_beat_cnt
`endif
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_next_state;
    logic           w_adv;
    logic           w_accept;
    logic           w_done;
    logic [ROW-1:0] r_last;

    assign w_adv    = out_ready;
    assign in_ready = out_ready && (r_state != c_DRAIN);
    assign w_accept = in_valid && in_ready;

    // Each lane is its own chain of r+1 stages; the last stage drives the grid.
    for (genvar r = 0; r < ROW; r++) begin : g_lane
        logic [DATA_W-1:0] r_dat [0:r];
        logic              r_vld [0:r];

        always_ff @(posedge in_clk) begin
            if (!in_rst_n) begin
                for (int s = 0; s <= r; s++) begin
                    r_dat[s] <= '0;
                    r_vld[s] <= 1'b0;
                end
            end else if (w_adv) begin
                r_dat[0] <= w_accept ? in_west[r*DATA_W +: DATA_W] : '0;
                r_vld[0] <= w_accept;
                for (int s = 1; s <= r; s++) begin
                    r_dat[s] <= r_dat[s-1];
                    r_vld[s] <= r_vld[s-1];
                end
            end
        end

        assign out_west[r*DATA_W +: DATA_W] = r_dat[r];
        assign out_lane_valid[r]            = r_vld[r];
    end

    // Last tag travels alongside the bottom lane only.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_last <= '0;
        end else if (w_adv) begin
            r_last[0] <= w_accept && in_last;
            for (int s = 1; s < ROW; s++) begin
                r_last[s] <= r_last[s-1];
            end
        end
    end

    assign w_done   = out_lane_valid[ROW-1] && r_last[ROW-1] && (r_state == c_DRAIN);
    assign out_done = w_done;
    assign out_busy = (r_state != c_IDLE);

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = in_last ? c_DRAIN : c_STREAM;
                end
            end
            c_STREAM: begin
                if (w_accept && in_last) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_adv && w_done) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

`ifdef SKEW_FEEDER_STATS_EN
    logic [15:0] r_beat_cnt;

    // An accept in IDLE starts a new tile, so the count restarts at one.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= (r_state == c_IDLE) ? 16'd1 : r_beat_cnt + 16'd1;
        end
    end

    assign out_beat_cnt = r_beat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
// ============================================================================
// Module  : tb_systolic_skew_feeder
// Brief   : Directed self-checking bench for systolic_skew_feeder (ROW=4,
//           DATA_W=8) with hand-computed expected vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_skew_feeder;

    localparam int ROW    = 4;
    localparam int DATA_W = 8;

    logic                  clk;
    logic                  rst_n;
    logic [ROW*DATA_W-1:0] in_west;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_ready;
    logic [ROW*DATA_W-1:0] out_west;
    logic [ROW-1:0]        out_lane_valid;
    logic                  out_done;
    logic                  out_busy;
`ifdef SKEW_FEEDER_STATS_EN
    logic [15:0]           out_beat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    systolic_skew_feeder #(
        .ROW    (ROW),
        .DATA_W (DATA_W)
    ) u_dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_west        (in_west),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .out_west       (out_west),
        .out_lane_valid (out_lane_valid),
        .out_done       (out_done),
        .out_busy       (out_busy)
`ifdef SKEW_FEEDER_STATS_EN
        ,
        .out_beat_cnt   (out_beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: data, lane valids, ready, done, busy.
    task automatic check_all(input string tag, input logic [31:0] w, input logic [3:0] lv,
                             input logic rdy, input logic dn, input logic bsy);
        check({tag, ".west"},  out_west, w);
        check({tag, ".lv"},    {28'd0, out_lane_valid}, {28'd0, lv});
        check({tag, ".ready"}, {31'd0, in_ready}, {31'd0, rdy});
        check({tag, ".done"},  {31'd0, out_done}, {31'd0, dn});
        check({tag, ".busy"},  {31'd0, out_busy}, {31'd0, bsy});
    endtask

    task automatic beat(input logic [31:0] w, input logic last);
        in_west  = w;
        in_valid = 1'b1;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_west  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_in();

        // Reset then idle
        tick();
        tick();
        check_all("rst", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_all("idle", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Single 3-beat tile, no stalls
        beat(32'h13121110, 1'b0); tick();
        check_all("t1.e1", 32'h00000010, 4'b0001, 1'b1, 1'b0, 1'b1);
        beat(32'h23222120, 1'b0); tick();
        check_all("t1.e2", 32'h00001120, 4'b0011, 1'b1, 1'b0, 1'b1);
        beat(32'h33323130, 1'b1); tick();
        check_all("t1.e3", 32'h00122130, 4'b0111, 1'b0, 1'b0, 1'b1);
        idle_in(); tick();
        check_all("t1.e4", 32'h13223100, 4'b1110, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("t1.e5", 32'h23320000, 4'b1100, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("t1.e6", 32'h33000000, 4'b1000, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("t1.e7", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Same tile with stalls mid-drain and while done is up
        beat(32'h13121110, 1'b0); tick();
        beat(32'h23222120, 1'b0); tick();
        beat(32'h33323130, 1'b1); tick();
        check_all("bp.e3", 32'h00122130, 4'b0111, 1'b0, 1'b0, 1'b1);
        idle_in(); tick();
        check_all("bp.e4", 32'h13223100, 4'b1110, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        tick();
        check_all("bp.s1", 32'h13223100, 4'b1110, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("bp.s2", 32'h13223100, 4'b1110, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        check_all("bp.e5", 32'h23320000, 4'b1100, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("bp.e6", 32'h33000000, 4'b1000, 1'b0, 1'b1, 1'b1);
        out_ready = 1'b0;
        tick();
        check_all("bp.hold", 32'h33000000, 4'b1000, 1'b0, 1'b1, 1'b1);
        out_ready = 1'b1;
        tick();
        check_all("bp.e7", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Bubble between beat A and last beat B
        beat(32'hA3A2A1A0, 1'b0); tick();
        check_all("bu.e1", 32'h000000A0, 4'b0001, 1'b1, 1'b0, 1'b1);
        idle_in(); tick();
        check_all("bu.e2", 32'h0000A100, 4'b0010, 1'b1, 1'b0, 1'b1);
        beat(32'hB3B2B1B0, 1'b1); tick();
        check_all("bu.e3", 32'h00A200B0, 4'b0101, 1'b0, 1'b0, 1'b1);
        idle_in(); tick();
        check_all("bu.e4", 32'hA300B100, 4'b1010, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("bu.e5", 32'h00B20000, 4'b0100, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("bu.e6", 32'hB3000000, 4'b1000, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("bu.e7", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a tile discards everything
        beat(32'h13121110, 1'b0); tick();
        beat(32'h23222120, 1'b0); tick();
        beat(32'h33323130, 1'b0); tick();
        check_all("mr.pre", 32'h00122130, 4'b0111, 1'b1, 1'b0, 1'b1);
        idle_in();
        rst_n = 1'b0;
        tick();
        check_all("mr.rst", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("mr.after", 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        end

`ifdef SKEW_FEEDER_STATS_EN
        // 5-beat tile then a 2-beat tile
        for (int i = 0; i < 5; i++) begin
            beat(32'h01010101 * (i + 1), (i == 4)); tick();
        end
        idle_in();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (out_done) seen = 1'b1;
                else tick();
            end
            check("st.done_seen", {31'd0, seen}, 32'd1);
        end
        check("st.cnt5", {16'd0, out_beat_cnt}, 32'd5);
        tick();
        check("st.hold", {16'd0, out_beat_cnt}, 32'd5);
        beat(32'h44444444, 1'b0); tick();
        check("st.cnt1", {16'd0, out_beat_cnt}, 32'd1);
        beat(32'h55555555, 1'b1); tick();
        check("st.cnt2", {16'd0, out_beat_cnt}, 32'd2);
        idle_in();
        for (int i = 0; i < 8; i++) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
